// File: rtl/gates_pkg.sv
// Shared types and constants for the 4-bit gates datapath and its operand loader.
//   GATES_NBITS    : operand width of the gates block
//   loader_state_t : operand loader FSM states
//   pair_t         : one (in0, in1) operand pair as carried through the pair queue
package gates_pkg;

    localparam int unsigned GATES_NBITS = 4;

    typedef enum logic {
        WAIT_A = 1'b0,
        WAIT_B = 1'b1
    } loader_state_t;

    typedef struct packed {
        logic [GATES_NBITS-1:0] in0;
        logic [GATES_NBITS-1:0] in1;
    } pair_t;

endpackage

// File: rtl/gates_pair_queue.sv
// Two-entry FIFO of operand pairs.
//   clk, reset : clock, synchronous active-high reset
//   enq        : push enq_data this cycle (never asserted while full)
//   enq_data   : pair to push
//   deq        : pop the head this cycle (caller gates with head_val)
//   count      : number of stored pairs, 0..2
//   head_val   : registered count!=0
//   head_data  : registered head entry
module gates_pair_queue
    import gates_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enq,
    input  pair_t      enq_data,
    input  logic       deq,
    output logic [1:0] count,
    output logic       head_val,
    output pair_t      head_data
);

    logic [1:0] count_q, count_d;
    logic [1:0] occ;
    logic       val_q, val_d;
    pair_t      e0_q, e0_d;
    pair_t      e1_q, e1_d;

    // Pop shifts entry 1 forward; push lands in the first slot free after the pop.
    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        occ     = 2'(count_q - 2'(deq));
        count_d = 2'(occ + 2'(enq));
        if (deq) begin
            e0_d = e1_q;
        end
        if (enq) begin
            if (occ == 2'd0) begin
                e0_d = enq_data;
            end else begin
                e1_d = enq_data;
            end
        end
        val_d = (count_d != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 2'd0;
            val_q   <= 1'b0;
            e0_q    <= '0;
            e1_q    <= '0;
        end else begin
            count_q <= count_d;
            val_q   <= val_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
        end
    end

    assign count     = count_q;
    assign head_val  = val_q;
    assign head_data = e0_q;

endmodule

// File: rtl/gates_operand_loader.sv
// Pairs a serial nibble stream into (in0, in1) operands and buffers up to two
// pairs for the gates block.
//   clk, reset  : clock, synchronous active-high reset
//   clear       : abort a half-assembled pair (queue untouched)
//   in_val/in_rdy/in_data : nibble input handshake; in_rdy is combinational
//                           from state, queue count, clear and reset only
//   out_val/out_rdy       : head pair handshake
//   out_in0/out_in1       : registered head pair operands
//   pair_count            : pairs enqueued since reset, modulo 256
module gates_operand_loader
    import gates_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   in_val,
    output logic                   in_rdy,
    input  logic [GATES_NBITS-1:0] in_data,
    output logic                   out_val,
    input  logic                   out_rdy,
    output logic [GATES_NBITS-1:0] out_in0,
    output logic [GATES_NBITS-1:0] out_in1,
    output logic [7:0]             pair_count
);

    localparam int unsigned NBITS = GATES_NBITS;

    loader_state_t    state_q, state_d;
    logic [NBITS-1:0] a_q, a_d;
    logic [7:0]       pair_count_q, pair_count_d;

    logic       in_fire;
    logic       enq;
    logic       deq;
    logic [1:0] q_count;
    logic       q_val;
    pair_t      q_head;
    pair_t      enq_pair;

    // Handshake decode and FSM next state.
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        pair_count_d = pair_count_q;
        enq_pair     = '{in0: a_q, in1: in_data};
        // Acceptance never looks at out_rdy, so a full queue stalls one cycle after a pop.
        in_rdy       = !reset && !clear && ((state_q == WAIT_A) || (q_count != 2'd2));
        in_fire      = in_val && in_rdy;
        enq          = in_fire && (state_q == WAIT_B);
        deq          = q_val && out_rdy;
        if (clear) begin
            state_d = WAIT_A;
        end else if (in_fire) begin
            case (state_q)
                WAIT_A: begin
                    a_d     = in_data;
                    state_d = WAIT_B;
                end
                WAIT_B: begin
                    pair_count_d = 8'(pair_count_q + 8'd1);
                    state_d      = WAIT_A;
                end
                default: state_d = WAIT_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= WAIT_A;
            a_q          <= '0;
            pair_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            pair_count_q <= pair_count_d;
        end
    end

    gates_pair_queue u_queue (
        .clk       (clk),
        .reset     (reset),
        .enq       (enq),
        .enq_data  (enq_pair),
        .deq       (deq),
        .count     (q_count),
        .head_val  (q_val),
        .head_data (q_head)
    );

    assign out_val    = q_val;
    assign out_in0    = q_head.in0;
    assign out_in1    = q_head.in1;
    assign pair_count = pair_count_q;

endmodule

// File: tb/tb_gates_operand_loader.sv
// Directed bench for gates_operand_loader with a behavioural gates block on its outputs.
module tb_gates_operand_loader;

    logic       clk;
    logic       reset;
    logic       clear;
    logic       in_val;
    logic       in_rdy;
    logic [3:0] in_data;
    logic       out_val;
    logic       out_rdy;
    logic [3:0] out_in0;
    logic [3:0] out_in1;
    logic [7:0] pair_count;

    int n_cmp  = 0;
    int n_fail = 0;

    // Downstream gates block, purely combinational on the head pair.
    logic [3:0] g_and, g_nand, g_or, g_nor;
    assign g_and  = out_in0 & out_in1;
    assign g_nand = ~(out_in0 & out_in1);
    assign g_or   = out_in0 | out_in1;
    assign g_nor  = ~(out_in0 | out_in1);

    gates_operand_loader dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .in_val     (in_val),
        .in_rdy     (in_rdy),
        .in_data    (in_data),
        .out_val    (out_val),
        .out_rdy    (out_rdy),
        .out_in0    (out_in0),
        .out_in1    (out_in1),
        .pair_count (pair_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] d);
        in_val  = 1'b1;
        in_data = d;
        tick();
        in_val  = 1'b0;
    endtask

    task automatic chk_head(input string tag, input logic [3:0] e0, input logic [3:0] e1);
        chk({tag, "_val"}, 32'(out_val), 32'd1);
        chk({tag, "_in0"}, 32'(out_in0), 32'(e0));
        chk({tag, "_in1"}, 32'(out_in1), 32'(e1));
    endtask

    initial begin
        reset   = 1'b1;
        clear   = 1'b0;
        in_val  = 1'b0;
        in_data = 4'h0;
        out_rdy = 1'b0;
        #1;
        chk("rdy_in_reset", 32'(in_rdy), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_in_rdy", 32'(in_rdy), 32'd1);
        chk("rst_out_val", 32'(out_val), 32'd0);
        chk("rst_in0", 32'(out_in0), 32'd0);
        chk("rst_in1", 32'(out_in1), 32'd0);
        chk("rst_pc", 32'(pair_count), 32'd0);

        // Basic pair 0xC,0xA.
        out_rdy = 1'b1;
        send(4'hC);
        chk("basic_half_val", 32'(out_val), 32'd0);
        send(4'hA);
        chk_head("basic", 4'hC, 4'hA);
        chk("basic_and", 32'(g_and), 32'h8);
        chk("basic_nand", 32'(g_nand), 32'h7);
        chk("basic_or", 32'(g_or), 32'hE);
        chk("basic_nor", 32'(g_nor), 32'h1);
        chk("basic_pc", 32'(pair_count), 32'd1);
        tick();
        chk("basic_drained", 32'(out_val), 32'd0);

        // Backpressure until full, then one stalled nibble.
        out_rdy = 1'b0;
        send(4'h0);
        send(4'hF);
        send(4'hF);
        send(4'h0);
        chk("full_pc", 32'(pair_count), 32'd3);
        chk_head("full_head", 4'h0, 4'hF);
        send(4'h3);
        in_val  = 1'b1;
        in_data = 4'h5;
        #1;
        chk("full_stall_rdy", 32'(in_rdy), 32'd0);
        tick();
        chk("full_still_stall", 32'(in_rdy), 32'd0);
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        chk_head("after_pop", 4'hF, 4'h0);
        chk("after_pop_pc", 32'(pair_count), 32'd3);
        chk("after_pop_rdy", 32'(in_rdy), 32'd1);
        tick();
        in_val = 1'b0;
        chk("stalled_accepted_pc", 32'(pair_count), 32'd4);
        chk_head("head_kept", 4'hF, 4'h0);
        out_rdy = 1'b1;
        tick();
        chk_head("second_pair", 4'h3, 4'h5);
        tick();
        chk("bp_drained", 32'(out_val), 32'd0);
        out_rdy = 1'b0;

        // Simultaneous enqueue and dequeue at count 1.
        send(4'h1);
        send(4'h2);
        chk_head("sim_pre", 4'h1, 4'h2);
        send(4'h4);
        in_val  = 1'b1;
        in_data = 4'h8;
        out_rdy = 1'b1;
        tick();
        in_val  = 1'b0;
        out_rdy = 1'b0;
        chk_head("sim_post", 4'h4, 4'h8);
        chk("sim_pc", 32'(pair_count), 32'd6);
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        chk("sim_single", 32'(out_val), 32'd0);

        // Clear discards a staged nibble, queue untouched.
        send(4'h7);
        send(4'hE);
        send(4'h3);
        clear   = 1'b1;
        in_val  = 1'b1;
        in_data = 4'hD;
        #1;
        chk("clr_rdy", 32'(in_rdy), 32'd0);
        tick();
        clear  = 1'b0;
        in_val = 1'b0;
        chk_head("clr_queue", 4'h7, 4'hE);
        chk("clr_pc", 32'(pair_count), 32'd7);
        send(4'h6);
        send(4'h9);
        chk("clr_pc2", 32'(pair_count), 32'd8);
        out_rdy = 1'b1;
        tick();
        chk_head("clr_pair", 4'h6, 4'h9);
        tick();
        chk("clr_drained", 32'(out_val), 32'd0);

        // pair_count wrap: 248 more pairs bring it from 8 to 256 == 0.
        for (int i = 0; i < 248; i++) begin
            send(4'(i));
            send(4'(~i));
        end
        chk("wrap_pc0", 32'(pair_count), 32'd0);
        chk_head("wrap_head", 4'(247), 4'(~247));
        send(4'h2);
        send(4'h4);
        chk("wrap_pc1", 32'(pair_count), 32'd1);
        tick();
        out_rdy = 1'b0;

        // Reset with two queued pairs and A staged.
        send(4'hA);
        send(4'hB);
        send(4'hC);
        send(4'hD);
        send(4'hE);
        chk("pre_rst_pc", 32'(pair_count), 32'd3);
        chk("pre_rst_rdy", 32'(in_rdy), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_val", 32'(out_val), 32'd0);
        chk("mid_rst_rdy", 32'(in_rdy), 32'd1);
        chk("mid_rst_pc", 32'(pair_count), 32'd0);
        send(4'h5);
        chk("mid_rst_half", 32'(out_val), 32'd0);
        send(4'h6);
        chk_head("mid_rst_pair", 4'h5, 4'h6);
        chk("mid_rst_pc1", 32'(pair_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
